// File: rtl/vga_timing_engine_if.sv
// Pixel-source handshake and VGA pin bundle for the timing engine.
// The master side is the timing engine; the slave side is the frame-buffer read path and pins.
interface vga_timing_engine_if #(
    parameter int unsigned CNT_W  = 11,
    parameter int unsigned DATA_W = 16
);
    logic              disp_en;
    logic [DATA_W-1:0] pixel_data;
    logic              pixel_valid;
    logic              clr_underflow;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_de;
    logic [DATA_W-1:0] vga_rgb;
    logic              data_req;
    logic [CNT_W-1:0]  pixel_xpos;
    logic [CNT_W-1:0]  pixel_ypos;
    logic              frame_start;
    logic              line_start;
    logic              underflow;

    modport master (
        input  disp_en, pixel_data, pixel_valid, clr_underflow,
        output vga_hs, vga_vs, vga_de, vga_rgb, data_req, pixel_xpos, pixel_ypos,
               frame_start, line_start, underflow
    );

    modport slave (
        output disp_en, pixel_data, pixel_valid, clr_underflow,
        input  vga_hs, vga_vs, vga_de, vga_rgb, data_req, pixel_xpos, pixel_ypos,
               frame_start, line_start, underflow
    );
endinterface

// File: rtl/vga_timing_engine.sv
// Parametrised VGA/LCD timing generator and pixel sink with early pixel request,
// frame-synchronous display enable, frame/line markers and a sticky underflow monitor.
module vga_timing_engine #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned DATA_W   = 16,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned REQ_LEAD = 1
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    vga_timing_engine_if.master bus
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HA      = H_SYNC + H_BACK;
    localparam int unsigned VA      = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] DE_H_LO  = CNT_W'(HA);
    localparam logic [CNT_W-1:0] DE_H_HI  = CNT_W'(HA + H_DISP);
    localparam logic [CNT_W-1:0] RQ_H_LO  = CNT_W'(HA - REQ_LEAD);
    localparam logic [CNT_W-1:0] RQ_H_HI  = CNT_W'(HA + H_DISP - REQ_LEAD);
    localparam logic [CNT_W-1:0] V_LO     = CNT_W'(VA);
    localparam logic [CNT_W-1:0] V_HI     = CNT_W'(VA + V_DISP);

    logic [CNT_W-1:0]  cnt_h;
    logic [CNT_W-1:0]  cnt_v;
    logic              frame_en;
    logic              vga_hs_q;
    logic              vga_vs_q;
    logic              vga_de_q;
    logic              data_req_q;
    logic [CNT_W-1:0]  pixel_xpos_q;
    logic [CNT_W-1:0]  pixel_ypos_q;
    logic              frame_start_q;
    logic              line_start_q;
    logic              underflow_q;

    logic              v_win_c;
    logic              de_c;
    logic              req_c;
    logic              at_origin_c;
    logic              uf_set_c;

    // Window decode on the current counter state; frame_en never matters at cnt_h==0.
    always_comb begin
        v_win_c     = 1'b0;
        de_c        = 1'b0;
        req_c       = 1'b0;
        at_origin_c = 1'b0;
        uf_set_c    = 1'b0;
        v_win_c     = (cnt_v >= V_LO) && (cnt_v < V_HI);
        de_c        = frame_en && v_win_c && (cnt_h >= DE_H_LO) && (cnt_h < DE_H_HI);
        req_c       = frame_en && v_win_c && (cnt_h >= RQ_H_LO) && (cnt_h < RQ_H_HI);
        at_origin_c = (cnt_h == '0) && (cnt_v == '0);
        uf_set_c    = vga_de_q && !bus.pixel_valid;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h         <= '0;
            cnt_v         <= '0;
            frame_en      <= 1'b0;
            vga_hs_q      <= HS_POL;
            vga_vs_q      <= VS_POL;
            vga_de_q      <= 1'b0;
            data_req_q    <= 1'b0;
            pixel_xpos_q  <= '0;
            pixel_ypos_q  <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            cnt_h <= (cnt_h == H_LAST) ? '0 : cnt_h + CNT_W'(1);
            if (cnt_h == H_LAST) begin
                cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + CNT_W'(1);
            end
            if (at_origin_c) begin
                frame_en <= bus.disp_en;
            end
            vga_hs_q      <= (cnt_h < H_SYNC_C) ? HS_POL : ~HS_POL;
            vga_vs_q      <= (cnt_v < V_SYNC_C) ? VS_POL : ~VS_POL;
            vga_de_q      <= de_c;
            data_req_q    <= req_c;
            pixel_xpos_q  <= req_c ? cnt_h - RQ_H_LO : '0;
            pixel_ypos_q  <= req_c ? cnt_v - V_LO : '0;
            frame_start_q <= at_origin_c;
            line_start_q  <= (cnt_h == '0);
            // Set has priority over clear.
            underflow_q   <= uf_set_c | (underflow_q & ~bus.clr_underflow);
        end
    end

    assign bus.vga_hs      = vga_hs_q;
    assign bus.vga_vs      = vga_vs_q;
    assign bus.vga_de      = vga_de_q;
    assign bus.data_req    = data_req_q;
    assign bus.pixel_xpos  = pixel_xpos_q;
    assign bus.pixel_ypos  = pixel_ypos_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_start  = line_start_q;
    assign bus.underflow   = underflow_q;
    assign bus.vga_rgb     = (vga_de_q && bus.pixel_valid) ? bus.pixel_data : '0;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine on a small timing: positional reference model, randomized
// enable/valid/clear stimulus, a latency-correct pixel source and literal frame measurements.
module tb_vga_timing_engine;

    localparam int unsigned HS = 4, HB = 3, HD = 8, HF = 2;
    localparam int unsigned VS = 1, VB = 1, VD = 4, VF = 1;
    localparam int unsigned CW = 6, DW = 8, RL = 3;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int HT = 17, VT = 7, FT = 119, HA = 7, VA = 2;

    logic vga_clk;
    logic sys_rst_n;

    vga_timing_engine_if #(.CNT_W(CW), .DATA_W(DW)) bus ();

    vga_timing_engine #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .CNT_W(CW), .DATA_W(DW), .HS_POL(HP), .VS_POL(VP), .REQ_LEAD(RL)
    ) dut (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix_fn(input int x, input int y);
        return DW'(x * 37 + y * 11 + 5);
    endfunction

    // Reference model: position since reset release gives (h, v) directly.
    int pos, mh, mv, mk;
    bit fe, m_uf, m_de, m_req, m_hs, m_vs, m_fs, m_ls, vwin;
    int m_x, m_y;
    logic [DW-1:0] m_rgb;

    always @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            pos = 0; fe = 0; m_uf = 0; m_de = 0; m_req = 0;
        end else begin
            mk = pos % FT;
            mh = mk % HT;
            mv = mk / HT;
            pos++;
            if (mh == 0 && mv == 0) fe = bus.disp_en;
            m_uf  = (m_de && !bus.pixel_valid) ? 1'b1 : (bus.clr_underflow ? 1'b0 : m_uf);
            m_hs  = (mh < HS) ? HP : !HP;
            m_vs  = (mv < VS) ? VP : !VP;
            vwin  = (mv >= VA) && (mv < VA + VD);
            m_de  = fe && vwin && (mh >= HA) && (mh < HA + HD);
            m_req = fe && vwin && (mh >= HA - RL) && (mh < HA + HD - RL);
            m_x   = m_req ? mh - (HA - RL) : 0;
            m_y   = m_req ? mv - VA : 0;
            m_fs  = (mh == 0) && (mv == 0);
            m_ls  = (mh == 0);
            #1;
            if (sys_rst_n) begin
                chk("hs", 32'(bus.vga_hs), 32'(m_hs));
                chk("vs", 32'(bus.vga_vs), 32'(m_vs));
                chk("de", 32'(bus.vga_de), 32'(m_de));
                chk("data_req", 32'(bus.data_req), 32'(m_req));
                chk("xpos", 32'(bus.pixel_xpos), 32'(m_x));
                chk("ypos", 32'(bus.pixel_ypos), 32'(m_y));
                chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
                chk("line_start", 32'(bus.line_start), 32'(m_ls));
                chk("underflow", 32'(bus.underflow), 32'(m_uf));
            end
            #3;
            if (sys_rst_n) begin
                m_rgb = (m_de && bus.pixel_valid) ? pix_fn(mh - HA, mv - VA) : '0;
                chk("rgb", 32'(bus.vga_rgb), 32'(m_rgb));
            end
        end
    end

    // Pixel source: answers each request exactly RL clocks later.
    bit hreq[RL+1];
    int hx[RL+1];
    int hy[RL+1];

    always @(posedge vga_clk) begin
        #2;
        if (!sys_rst_n) begin
            for (int i = 0; i <= RL; i++) begin hreq[i] = 0; hx[i] = 0; hy[i] = 0; end
            bus.pixel_data = '0;
        end else begin
            for (int i = RL; i > 0; i--) begin
                hreq[i] = hreq[i-1]; hx[i] = hx[i-1]; hy[i] = hy[i-1];
            end
            hreq[0] = bus.data_req;
            hx[0]   = int'(bus.pixel_xpos);
            hy[0]   = int'(bus.pixel_ypos);
            bus.pixel_data = hreq[RL] ? pix_fn(hx[RL], hy[RL]) : DW'($urandom);
        end
    end

    task automatic tick();
        @(posedge vga_clk);
        #2;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin tick(); n++; end while (!bus.frame_start && n < 300);
        chk("wait_frame_start_timeout", 32'(bus.frame_start), 32'd1);
    endtask

    // Call in a frame_start cycle; counts one whole frame and ends on the next frame_start.
    task automatic measure_frame(input int exp_de, input int exp_rises);
        int de_n = 0, req_n = 0, hs_n = 0, vs_n = 0, rises = 0;
        bit de_last = 0;
        for (int i = 0; i < FT; i++) begin
            if (bus.vga_de) de_n++;
            if (bus.data_req) req_n++;
            if (bus.vga_hs == HP) hs_n++;
            if (bus.vga_vs == VP) vs_n++;
            if (bus.vga_de && !de_last) rises++;
            de_last = bus.vga_de;
            tick();
        end
        chk("frame_de_clocks", 32'(de_n), 32'(exp_de));
        chk("frame_req_clocks", 32'(req_n), 32'(exp_de));
        chk("frame_de_lines", 32'(rises), 32'(exp_rises));
        chk("frame_hs_active", 32'(hs_n), 32'(HS * VT));
        chk("frame_vs_active", 32'(vs_n), 32'(VS * HT));
        chk("frame_period", 32'(bus.frame_start), 32'd1);
    endtask

    task automatic wait_model_de();
        int n = 0;
        while (!m_de && n < 300) begin tick(); n++; end
        chk("wait_de_timeout", 32'(m_de), 32'd1);
    endtask

    initial begin
        int n, de_at;
        sys_rst_n = 1'b0;
        bus.disp_en = 1'b1;
        bus.pixel_valid = 1'b1;
        bus.clr_underflow = 1'b0;
        repeat (3) tick();
        chk("rst_hs", 32'(bus.vga_hs), 32'(HP));
        chk("rst_vs", 32'(bus.vga_vs), 32'(VP));
        chk("rst_de", 32'(bus.vga_de), 32'd0);
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_fs", 32'(bus.frame_start), 32'd0);
        chk("rst_uf", 32'(bus.underflow), 32'd0);
        sys_rst_n = 1'b1;

        tick();
        chk("first_frame_start", 32'(bus.frame_start), 32'd1);
        measure_frame(HD * VD, VD);

        // Request lead and request length in frame 1.
        n = 0;
        while (!bus.data_req && n < 300) begin tick(); n++; end
        chk("req_rise_timeout", 32'(bus.data_req), 32'd1);
        n = 0; de_at = -1;
        while (bus.data_req && n < 50) begin
            if (bus.vga_de && de_at < 0) de_at = n;
            n++;
            tick();
        end
        chk("req_to_de_lead", 32'(de_at), 32'(RL));
        chk("req_length", 32'(n), 32'(HD));

        // Drop display enable mid-frame; the next frame is blank, sync continues.
        n = 0;
        while (mv != 3 && n < 300) begin tick(); n++; end
        bus.disp_en = 1'b0;
        wait_fs();
        measure_frame(0, 0);
        bus.disp_en = 1'b1;
        wait_fs();
        measure_frame(HD * VD, VD);

        // Underflow: single miss, set+clear together, clear alone.
        bus.clr_underflow = 1'b1;
        tick();
        bus.clr_underflow = 1'b0;
        wait_model_de();
        bus.pixel_valid = 1'b0;
        #1 chk("rgb_on_miss", 32'(bus.vga_rgb), 32'd0);
        tick();
        bus.pixel_valid = 1'b1;
        chk("uf_set", 32'(bus.underflow), 32'd1);
        repeat (5) tick();
        chk("uf_sticky", 32'(bus.underflow), 32'd1);
        wait_model_de();
        bus.pixel_valid = 1'b0;
        bus.clr_underflow = 1'b1;
        tick();
        bus.pixel_valid = 1'b1;
        chk("uf_set_beats_clear", 32'(bus.underflow), 32'd1);
        tick();
        bus.clr_underflow = 1'b0;
        chk("uf_cleared", 32'(bus.underflow), 32'd0);

        // Randomized enable / valid / clear traffic.
        for (int i = 0; i < 1400; i++) begin
            tick();
            if ($urandom_range(0, 149) == 0) bus.disp_en = ~bus.disp_en;
            bus.pixel_valid   = ($urandom_range(0, 11) != 0);
            bus.clr_underflow = ($urandom_range(0, 7) == 0);
        end
        bus.pixel_valid = 1'b1;
        bus.clr_underflow = 1'b0;
        bus.disp_en = 1'b1;
        repeat (2 * FT) tick();

        // Reset in the middle of an active line.
        wait_model_de();
        #1 sys_rst_n = 1'b0;
        #1;
        chk("midrst_hs", 32'(bus.vga_hs), 32'(HP));
        chk("midrst_vs", 32'(bus.vga_vs), 32'(VP));
        chk("midrst_de", 32'(bus.vga_de), 32'd0);
        chk("midrst_req", 32'(bus.data_req), 32'd0);
        chk("midrst_xpos", 32'(bus.pixel_xpos), 32'd0);
        chk("midrst_ls", 32'(bus.line_start), 32'd0);
        chk("midrst_rgb", 32'(bus.vga_rgb), 32'd0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        chk("post_rst_frame_start", 32'(bus.frame_start), 32'd1);
        n = 0;
        do begin tick(); n++; end while (!bus.frame_start && n < 300);
        chk("post_rst_period", 32'(n), 32'(FT));
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_engine.md
Name: vga_timing_engine

Overview:
- Parametrised VGA/LCD timing generator and pixel sink. It succeeds the fixed 640x480 driver.
- Generalised in timing, counter width, pixel width, sync polarity and pixel-source latency.
- Adds frame/line markers, a frame-synchronous display enable and a pixel-underflow monitor.
- Sits between the frame-buffer read path (SDRAM/FIFO) and the VGA DAC pins.

Parameters:
- H_SYNC, 96: hsync width (clocks).
- H_BACK, 48: horizontal back porch.
- H_DISP, 640: active pixels per line.
- H_FRONT, 16: horizontal front porch.
- V_SYNC, 2: vsync width (lines).
- V_BACK, 33: vertical back porch.
- V_DISP, 480: active lines.
- V_FRONT, 10: vertical front porch.
- CNT_W, 11: width of the counters and coordinate outputs. Must hold H_TOTAL-1 and V_TOTAL-1.
- DATA_W, 16: pixel width (RGB565 default).
- HS_POL, 0: active level of vga_hs.
- VS_POL, 0: active level of vga_vs.
- REQ_LEAD, 1: clocks between data_req and the matching pixel_data. Legal range 1..H_SYNC+H_BACK-1.
- Derived: H_TOTAL = sum of the four H_* parameters; V_TOTAL likewise. HA = H_SYNC+H_BACK; VA = V_SYNC+V_BACK.

Ports:
- vga_clk, in, 1: pixel clock.
- sys_rst_n, in, 1: asynchronous active-low reset.
- disp_en, in, 1: display enable, sampled only at frame start.
- pixel_data, in, DATA_W: pixel from source.
- pixel_valid, in, 1: pixel_data is valid this clock.
- clr_underflow, in, 1: clears the sticky underflow flag.
- vga_hs, out, 1: horizontal sync.
- vga_vs, out, 1: vertical sync.
- vga_de, out, 1: active-video / blanking-inverse.
- vga_rgb, out, DATA_W: pixel output.
- data_req, out, 1: pixel request to source.
- pixel_xpos, out, CNT_W: column of the requested pixel.
- pixel_ypos, out, CNT_W: row of the requested pixel.
- frame_start, out, 1: one-clock pulse at frame start.
- line_start, out, 1: one-clock pulse at line start.
- underflow, out, 1: sticky flag, pixel missing during active video.

Behaviour:
- Counters
  - cnt_h counts 0..H_TOTAL-1 and wraps to 0.
  - cnt_v increments when cnt_h==H_TOTAL-1; it wraps to 0 after V_TOTAL-1.
- Registered outputs
  - Every output except vga_rgb is registered and reflects counter state one clock earlier.
  - vga_rgb = (vga_de && pixel_valid) ? pixel_data : 0, combinational from registered vga_de.
- Sync
  - vga_hs is at HS_POL when cnt_h < H_SYNC, otherwise at ~HS_POL.
  - vga_vs is at VS_POL when cnt_v < V_SYNC, otherwise at ~VS_POL.
  - Sync is never gated by disp_en.
- Active video and request
  - vga_de is high when cnt_h is in [HA, HA+H_DISP) and cnt_v is in [VA, VA+V_DISP), and frame_en==1.
  - data_req uses the same window shifted earlier by REQ_LEAD: cnt_h in [HA-REQ_LEAD, HA+H_DISP-REQ_LEAD), same vertical window and frame_en condition.
  - data_req therefore rises exactly REQ_LEAD clocks before vga_de and stays high for exactly H_DISP clocks per active line.
- Coordinates
  - pixel_xpos runs 0..H_DISP-1 while data_req is high; pixel_ypos = cnt_v-VA.
  - Both are 0 when data_req is low.
  - The pixel requested in clock t must be on pixel_data, with pixel_valid high, in clock t+REQ_LEAD.
- frame_enable
  - frame_en is loaded from disp_en only when cnt_h==0 and cnt_v==0.
  - Toggling disp_en mid-frame has no effect until the next frame start.
- frame_start pulses for one clock for counter state (0,0).
- line_start pulses for one clock for cnt_h==0 on every line, including blanking lines.
- underflow
  - Set on any clock with vga_de==1 and pixel_valid==0.
  - Held until a clock with clr_underflow==1 and no new underflow event.
  - If a set and a clear occur in the same clock, set wins.
- Reset
  - Counters go to 0 and frame_en to 0.
  - vga_hs=HS_POL and vga_vs=VS_POL (counter state 0 is inside sync).
  - vga_de, data_req, frame_start, line_start and underflow go to 0; pixel_xpos=pixel_ypos=0.
  - Reset asserted mid-line aborts immediately. After release, timing restarts at (0,0); the first frame_start appears one clock after the first active edge.
  - The first frame after reset is displayed only if disp_en is high at the first (0,0).

Test Plan:
- Defaults, disp_en=1, pixel_valid=1 -> hs low for 96 clocks every 800; vs low for 1600 clocks every 420000; vga_de high for 640 clocks with the rising edge 144 clocks after the hs falling edge; 480 DE lines per frame.
- REQ_LEAD=3, small timing (H 4/3/8/2, V 1/1/4/1) -> data_req rises exactly 3 clocks before vga_de; pixel_xpos runs 0..7; pixel_ypos runs 0..3; vga_rgb equals the pixel_data driven 3 clocks after each request.
- HS_POL=1, VS_POL=1 -> sync pulses are high with the same widths and period; vga_de is unchanged.
- disp_en dropped at line 100 -> the current frame completes 480 DE lines; the next frame has no data_req or DE while hs/vs continue; raising disp_en restores output from the frame after the next (0,0).
- pixel_valid forced low for 1 clock during DE -> vga_rgb=0 that clock and underflow=1 thereafter; clr_underflow pulsed in the same clock as another miss -> underflow stays 1; clr_underflow pulsed alone -> underflow=0.
- Reset asserted mid-active-line -> all outputs at reset values immediately; after release, frame_start fires once, one clock after the first edge, and the period is unchanged.
